fir_accumulator: RTL and testbench
==================================

// Module: fir_accumulator
// PURPOSE
//  Downstream stage of the pipelined signed multiplier in the FIR datapath.
//  - Consumes the 2*WIDTH-bit products and their delayed control bits, and sums TAPS products per output sample.
//  - Scales and optionally saturates the sum, then presents it through a 2-entry output buffer with a valid/ready handshake.
//  - The multiplier cannot stall, so back-pressure is reported upstream on `busy`.
// PARAMETERS
//  WIDTH                 16  sample/coefficient width; each product is 2*WIDTH bits, signed
//  TAPS                  8   products per output sample (>=2)
//  CONTROL_SIGNALS_WIDTH 3   control bus width; bit0=valid, bit1=first, bit2=last
//  SHIFT                 15  arithmetic right shift applied to the sum before narrowing (Q15)
//  OUT_WIDTH             16  output sample width
//  ACC_WIDTH (localparam) = 2*WIDTH + $clog2(TAPS)
// PORTS
//  clk            in   1          clock, rising edge
//  rst            in   1          asynchronous, active-high reset
//  product        in   2*WIDTH    signed product from the multiplier
//  ctrl           in   CSW        control bits delayed alongside product {last,first,valid}
//  out_data       out  OUT_WIDTH  filtered sample, signed
//  out_valid      out  1          out_data holds a sample
//  out_ready      in   1          consumer accepts the sample on out_valid&&out_ready
//  busy           out  1          buffer full: upstream must not issue a new `first`
//  overrun        out  1          sticky: a sample was dropped because the buffer was full
//  seq_err        out  1          sticky: malformed tap sequence detected
// BEHAVIOUR
//  - Reset (async): state=IDLE; acc=0; tap_cnt=0; buffer empty; every output is 0.
//  - Inputs are used only when ctrl.valid=1; cycles with valid=0 do not change state.
//  - FSM IDLE:
//    - valid&first: acc<=sext(product), tap_cnt<=1, go to ACCUM.
//    - valid&!first: set seq_err and drop the product.
//  - FSM ACCUM, on valid:
//    - acc<=acc+sext(product), tap_cnt++.
//    - valid&first: set seq_err and restart, acc<=product, tap_cnt<=1.
//    - valid&last: complete the sample and return to IDLE.
//    - If last arrives with tap_cnt+1 != TAPS: set seq_err, but the sample is still completed and pushed.
//  - first&last on the same beat is legal only if TAPS==1. For TAPS>=2 it sets seq_err and the beat is dropped.
//  - Completed sum S = acc + final product, at full ACC_WIDTH with no internal overflow.
//    - Narrowing: R = S >>> SHIFT (arithmetic shift), then R is reduced to OUT_WIDTH (see CONFIGURATION).
//  - Push: R is written to the buffer on the cycle after the last beat (one register stage).
//    - Latency from the last product to out_valid is 2 cycles.
//  - Buffer is 2 entries, first-in first-out.
//    - out_valid = !empty; out_data = head entry.
//    - Pop on out_valid&&out_ready.
//    - Push and pop in the same cycle when full: both take effect, with no overrun.
//    - Push when full with no pop: the new sample is dropped and overrun is set.
//    - busy = full || (1 entry held && a push is pending in the register stage).
//  - overrun and seq_err stay set until rst.
//  - out_data is stable while out_valid&&!out_ready.
//  - Reset mid-accumulation discards the partial sum and empties the buffer.
// CONFIGURATION
//  FIR_ACC_SATURATE_EN
//  - Defined: R is clipped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//  - Not defined: R is truncated to its low OUT_WIDTH bits (two's-complement wrap).
// STRUCTURE
//  - Package fir_pkg holds:
//    - localparams CTRL_VALID=0, CTRL_FIRST=1, CTRL_LAST=2;
//    - typedef enum logic {ST_IDLE, ST_ACCUM} acc_state_t;
//    - function sat_narrow(), shared with any other narrowing stage.
//  - Sub-module fir_out_fifo (DEPTH=2, DATA_W=OUT_WIDTH) provides full/empty/push/pop.
//  - The FSM, accumulator and narrowing logic live in this module.
// TESTING
//  - Reset: assert rst mid-stream -> all outputs 0, out_valid=0, flags 0, next first starts cleanly.
//  - 8 taps: products 1000 each, SHIFT=0 -> out_data=8000, out_valid 2 cycles after last.
//  - Q15 sign: products -16384 x8 (first..last), SHIFT=15 -> out_data=-4.
//  - Saturation: products 0x3FFF0000 x8, SHIFT=15:
//    - with FIR_ACC_SATURATE_EN -> out_data=32767;
//    - without it -> out_data equals the low 16 bits of (S>>>15).
//  - Back-pressure: out_ready=0, send 3 samples -> busy=1 after the 2nd is buffered, 3rd dropped, overrun=1, first two drain in order.
//  - Sequence errors: last after 5 taps -> seq_err=1 and the sample is still output; valid without first in IDLE -> product ignored.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - control bit indices, accumulator FSM states and shared narrowing helper
package fir_pkg;

  localparam int CTRL_VALID = 0;
  localparam int CTRL_FIRST = 1;
  localparam int CTRL_LAST  = 2;

  typedef enum logic {ST_IDLE, ST_ACCUM} acc_state_t;

  // Clip a sign-extended value into the signed range of an out_w-bit word
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                    input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// rtl/fir_out_fifo.sv - small first-in first-out output buffer with full/empty/count
module fir_out_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [DATA_W-1:0]            rd_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !empty;
  // A full buffer still accepts a push when the head leaves on the same edge
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fir_accumulator.sv
// rtl/fir_accumulator.sv - sums TAPS products per sample, scales, narrows and buffers them
// Optional clipping of the narrowed result: define FIR_ACC_SATURATE_EN.
module fir_accumulator
  import fir_pkg::*;
#(
  parameter int WIDTH                 = 16,
  parameter int TAPS                  = 8,
  parameter int CONTROL_SIGNALS_WIDTH = 3,
  parameter int SHIFT                 = 15,
  parameter int OUT_WIDTH             = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [2*WIDTH-1:0]           product,
  input  logic [CONTROL_SIGNALS_WIDTH-1:0]    ctrl,
  output logic signed [OUT_WIDTH-1:0]         out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                overrun,
  output logic                                seq_err
);

  localparam int ACC_WIDTH  = 2*WIDTH + $clog2(TAPS);
  localparam int CNT_W      = $clog2(TAPS) + 2;
  localparam int FIFO_CNT_W = $clog2(3);

  acc_state_t                  state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] sum_base;
  logic signed [ACC_WIDTH-1:0] sum_s;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [CNT_W-1:0]            tap_cnt;
  logic [OUT_WIDTH-1:0]        narrowed;
  logic                        in_valid;
  logic                        in_first;
  logic                        in_last;

  logic                        pend_valid;
  logic [OUT_WIDTH-1:0]        pend_data;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_pop;
  logic [FIFO_CNT_W-1:0]       fifo_count;
  logic [OUT_WIDTH-1:0]        fifo_rd_data;

  assign in_valid = ctrl[CTRL_VALID];
  assign in_first = ctrl[CTRL_FIRST];
  assign in_last  = ctrl[CTRL_LAST];

  assign prod_ext = ACC_WIDTH'(product);
  // The completing beat may arrive in IDLE only for a single-tap filter
  assign sum_base = (state == ST_ACCUM) ? acc : '0;
  assign sum_s    = sum_base + prod_ext;
  assign shifted  = sum_s >>> SHIFT;

`ifdef FIR_ACC_SATURATE_EN
  assign narrowed = OUT_WIDTH'(sat_narrow(64'(shifted), OUT_WIDTH));
`else
  assign narrowed = OUT_WIDTH'(shifted);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      acc        <= '0;
      tap_cnt    <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      overrun    <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      pend_valid <= 1'b0;
      if (pend_valid && fifo_full && !fifo_pop) overrun <= 1'b1;
      if (in_valid) begin
        if (in_first && in_last && (TAPS != 1)) begin
          seq_err <= 1'b1;
        end else if (state == ST_IDLE) begin
          if (!in_first) begin
            seq_err <= 1'b1;
          end else if (in_last) begin
            pend_valid <= 1'b1;
            pend_data  <= narrowed;
          end else begin
            acc     <= prod_ext;
            tap_cnt <= CNT_W'(1);
            state   <= ST_ACCUM;
          end
        end else begin
          if (in_first) begin
            seq_err <= 1'b1;
            acc     <= prod_ext;
            tap_cnt <= CNT_W'(1);
          end else if (in_last) begin
            if ((tap_cnt + CNT_W'(1)) != CNT_W'(TAPS)) seq_err <= 1'b1;
            pend_valid <= 1'b1;
            pend_data  <= narrowed;
            acc        <= '0;
            tap_cnt    <= '0;
            state      <= ST_IDLE;
          end else begin
            acc <= sum_s;
            if (tap_cnt != '1) tap_cnt <= tap_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  assign fifo_pop = !fifo_empty && out_ready;

  fir_out_fifo #(
    .DEPTH  (2),
    .DATA_W (OUT_WIDTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pend_valid),
    .push_data (pend_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .rd_data   (fifo_rd_data)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rd_data;
  assign busy      = fifo_full || ((fifo_count == FIFO_CNT_W'(1)) && pend_valid);

endmodule

// File: tb/tb_fir_accumulator.sv
// tb/tb_fir_accumulator.sv - directed checks of fir_accumulator with SHIFT=0 and SHIFT=15 instances
module tb_fir_accumulator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] product = '0;
  logic [2:0]         ctrl = '0;
  logic               out_ready = 1'b0;

  logic signed [15:0] a_data, q_data;
  logic a_valid, a_busy, a_ovr, a_seq;
  logic q_valid, q_busy, q_ovr, q_seq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_accumulator #(.WIDTH(16), .TAPS(8), .CONTROL_SIGNALS_WIDTH(3), .SHIFT(0), .OUT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .product(product), .ctrl(ctrl),
    .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
    .busy(a_busy), .overrun(a_ovr), .seq_err(a_seq)
  );

  fir_accumulator #(.WIDTH(16), .TAPS(8), .CONTROL_SIGNALS_WIDTH(3), .SHIFT(15), .OUT_WIDTH(16)) dut_q (
    .clk(clk), .rst(rst), .product(product), .ctrl(ctrl),
    .out_data(q_data), .out_valid(q_valid), .out_ready(out_ready),
    .busy(q_busy), .overrun(q_ovr), .seq_err(q_seq)
  );

  task automatic beat(input logic signed [31:0] p, input logic f, input logic l);
    @(negedge clk);
    product = p;
    ctrl    = {l, f, 1'b1};
  endtask

  task automatic idle();
    @(negedge clk);
    product = '0;
    ctrl    = 3'b000;
  endtask

  task automatic send(input logic signed [31:0] p, input int n);
    for (int i = 0; i < n; i++) beat(p, (i == 0), (i == n - 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b0; ctrl = '0; product = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({a_valid, a_busy, a_ovr, a_seq, a_data} !== 20'd0) begin
      bad++; $display("FAIL reset_state: got %h want 0", {a_valid, a_busy, a_ovr, a_seq, a_data});
    end
    rst = 1'b0;
    beat(32'sd5, 1'b0, 1'b0);
    send(32'sd1000, 8);
    idle(); idle();
    send(32'sd1000, 3);
    @(negedge clk);
    rst = 1'b1; ctrl = '0;
    #1;
    total++;
    if ({a_valid, a_busy, a_ovr, a_seq, a_data, q_valid, q_data} !== 37'd0) begin
      bad++; $display("FAIL reset_async: got %h want 0", {a_valid, a_busy, a_ovr, a_seq, a_data, q_valid, q_data});
    end
    @(negedge clk);
    rst = 1'b0;
    send(32'sd1000, 8);
    idle();
    total++;
    if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_latency: got %0b want 0", a_valid); end
    idle();
    total++;
    if ({a_valid, a_seq, a_data} !== {1'b1, 1'b0, 16'sd8000}) begin
      bad++; $display("FAIL reset_restart: got v=%0b e=%0b d=%0d want v=1 e=0 d=8000", a_valid, a_seq, a_data);
    end
    pop_one();
  endtask

  task automatic test_eight_taps();
    do_reset();
    send(32'sd1000, 8);
    idle();
    total++;
    if (a_valid !== 1'b0) begin bad++; $display("FAIL taps_latency1: got %0b want 0", a_valid); end
    idle();
    total++;
    if ({a_valid, a_data} !== {1'b1, 16'sd8000}) begin
      bad++; $display("FAIL taps_sum: got v=%0b d=%0d want v=1 d=8000", a_valid, a_data);
    end
    total++;
    if (q_data !== 16'sd0) begin bad++; $display("FAIL taps_q15: got %0d want 0", q_data); end
    pop_one();
    total++;
    if (a_valid !== 1'b0) begin bad++; $display("FAIL taps_drain: got %0b want 0", a_valid); end
  endtask

  task automatic test_q15_sign();
    do_reset();
    send(-32'sd16384, 8);
    idle(); idle();
    total++;
    if ({q_valid, q_data} !== {1'b1, -16'sd4}) begin
      bad++; $display("FAIL q15_sign: got v=%0b d=%0d want v=1 d=-4", q_valid, q_data);
    end
    pop_one();
  endtask

  task automatic test_saturation();
    logic signed [15:0] exp_q, exp_a;
`ifdef FIR_ACC_SATURATE_EN
    exp_q = 16'sd32767; exp_a = 16'sd32767;
`else
    exp_q = -16'sd16; exp_a = 16'sd0;
`endif
    do_reset();
    send(32'sh3FFF0000, 8);
    idle(); idle();
    total++;
    if (q_data !== exp_q) begin bad++; $display("FAIL sat_q15: got %0d want %0d", q_data, exp_q); end
    total++;
    if (a_data !== exp_a) begin bad++; $display("FAIL sat_shift0: got %0d want %0d", a_data, exp_a); end
    pop_one();
  endtask

  task automatic test_back_pressure();
    do_reset();
    send(32'sd100, 8);
    send(32'sd200, 8);
    idle(); idle();
    total++;
    if ({a_busy, a_ovr} !== 2'b10) begin
      bad++; $display("FAIL bp_busy: got busy=%0b ovr=%0b want busy=1 ovr=0", a_busy, a_ovr);
    end
    send(32'sd300, 8);
    idle(); idle();
    total++;
    if ({a_ovr, q_ovr, a_data} !== {2'b11, 16'sd800}) begin
      bad++; $display("FAIL bp_overrun: got ovr=%0b/%0b d=%0d want 1/1 d=800", a_ovr, q_ovr, a_data);
    end
    repeat (3) idle();
    total++;
    if ({a_valid, a_data} !== {1'b1, 16'sd800}) begin
      bad++; $display("FAIL bp_stable: got v=%0b d=%0d want v=1 d=800", a_valid, a_data);
    end
    pop_one();
    total++;
    if (a_data !== 16'sd1600) begin bad++; $display("FAIL bp_order: got %0d want 1600", a_data); end
    pop_one();
    total++;
    if ({a_valid, a_busy, a_ovr} !== 3'b001) begin
      bad++; $display("FAIL bp_empty: got v=%0b busy=%0b ovr=%0b want 0 0 1", a_valid, a_busy, a_ovr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(32'sd100, 8);
    send(32'sd200, 8);
    idle(); idle();
    send(32'sd300, 8);
    @(negedge clk);
    ctrl = '0; product = '0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({a_ovr, a_valid, a_data} !== {2'b01, 16'sd1600}) begin
      bad++; $display("FAIL b2b_pushpop: got ovr=%0b v=%0b d=%0d want ovr=0 v=1 d=1600", a_ovr, a_valid, a_data);
    end
    pop_one();
    total++;
    if (a_data !== 16'sd2400) begin bad++; $display("FAIL b2b_third: got %0d want 2400", a_data); end
    pop_one();
    total++;
    if (a_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %0b want 0", a_valid); end
  endtask

  task automatic test_seq_errors();
    do_reset();
    send(32'sd10, 5);
    idle(); idle();
    total++;
    if ({a_seq, a_valid, a_data} !== {2'b11, 16'sd50}) begin
      bad++; $display("FAIL seq_short: got e=%0b v=%0b d=%0d want e=1 v=1 d=50", a_seq, a_valid, a_data);
    end
    pop_one();
    do_reset();
    beat(32'sd777, 1'b0, 1'b0);
    idle();
    total++;
    if ({a_seq, a_valid} !== 2'b10) begin
      bad++; $display("FAIL seq_nofirst: got e=%0b v=%0b want e=1 v=0", a_seq, a_valid);
    end
    send(32'sd1000, 8);
    idle(); idle();
    total++;
    if (a_data !== 16'sd8000) begin bad++; $display("FAIL seq_ignored: got %0d want 8000", a_data); end
    pop_one();
    do_reset();
    beat(32'sd5, 1'b1, 1'b1);
    idle(); idle();
    total++;
    if ({a_seq, a_valid} !== 2'b10) begin
      bad++; $display("FAIL seq_firstlast: got e=%0b v=%0b want e=1 v=0", a_seq, a_valid);
    end
    do_reset();
    beat(32'sd999, 1'b1, 1'b0);
    beat(32'sd999, 1'b0, 1'b0);
    send(32'sd1000, 8);
    idle(); idle();
    total++;
    if ({a_seq, a_data} !== {1'b1, 16'sd8000}) begin
      bad++; $display("FAIL seq_restart: got e=%0b d=%0d want e=1 d=8000", a_seq, a_data);
    end
    pop_one();
  endtask

  initial begin
    test_reset();
    test_eight_taps();
    test_q15_sign();
    test_saturation();
    test_back_pressure();
    test_back_to_back();
    test_seq_errors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
